// File: rtl/rpn_alu_param.sv
// Reverse-Polish integer calculator: a 4-bit token stream drives a DEPTH-entry signed stack.
// Define RPN_ALU_SAT_EN to saturate arithmetic results instead of wrapping them.
module rpn_alu_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [DATA_W-1:0]        o_result,
  output logic                     o_result_valid,
  output logic                     o_error,
  output logic [1:0]               o_err_code,
  output logic [$clog2(DEPTH):0]   o_depth
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = 2 * DATA_W;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_STACK = 2'b10;
  localparam logic [1:0] ERR_ARITH = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state, next_state;
  logic [DATA_W-1:0]   stack [DEPTH];
  logic [PW-1:0]       depth;
  logic                alive;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   res_q;
  logic                ovf_q;

  logic [AW-1:0]       top_idx, sec_idx, push_idx;
  logic                accept, is_digit, is_op, is_eq, is_clr;
  logic                empty, full;
  logic                push_en, pop_en, err_set, clr_en, op_start;
  logic [DATA_W-1:0]   push_data;
  logic [1:0]          err_code_n;
  logic signed [WW-1:0] a_w, b_w, wide;

  assign top_idx  = AW'(depth - PW'(1));
  assign sec_idx  = AW'(depth - PW'(2));
  assign push_idx = AW'(depth);

  assign o_ready  = alive && (state == IDLE);
  assign o_depth  = depth;
  assign accept   = i_valid && o_ready;
  assign is_digit = (i_data <= 4'd9);
  assign is_op    = (i_data == 4'hA) || (i_data == 4'hB) || (i_data == 4'hC);
  assign is_eq    = (i_data == 4'hD);
  assign is_clr   = (i_data == 4'hF);
  assign empty    = (depth == '0);
  assign full     = (depth == FULL);

  // Held low through reset and raised on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    push_en    = 1'b0;
    push_data  = stack[top_idx];
    pop_en     = 1'b0;
    err_set    = 1'b0;
    err_code_n = 2'b00;
    clr_en     = 1'b0;
    op_start   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_clr) begin
            clr_en = 1'b1;
          end else if (!o_error) begin
            if (is_digit) begin
              if (full) begin
                err_set    = 1'b1;
                err_code_n = ERR_STACK;
              end else begin
                push_en   = 1'b1;
                push_data = DATA_W'(i_data);
              end
            end else if (is_op) begin
              if (depth < PW'(2)) begin
                err_set    = 1'b1;
                err_code_n = ERR_UNDER;
              end else begin
                op_start   = 1'b1;
                next_state = EXEC;
              end
            end else if (is_eq) begin
              if (empty) begin
                err_set    = 1'b1;
                err_code_n = ERR_UNDER;
              end else begin
                pop_en = 1'b1;
              end
            end else begin
              if (empty) begin
                err_set    = 1'b1;
                err_code_n = ERR_UNDER;
              end else if (full) begin
                err_set    = 1'b1;
                err_code_n = ERR_STACK;
              end else begin
                push_en = 1'b1;
              end
            end
          end
        end
      end
      EXEC: next_state = WB;
      WB: begin
        next_state = IDLE;
        if (ovf_q) begin
          err_set    = 1'b1;
          err_code_n = ERR_ARITH;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are sign-extended so the product of two DATA_W values always fits exactly.
  assign a_w = WW'($signed(stack[top_idx]));
  assign b_w = WW'($signed(stack[sec_idx]));

  always_comb begin
    case (op_q)
      2'b10:   wide = b_w + a_w;
      2'b11:   wide = b_w - a_w;
      default: wide = b_w * a_w;
    endcase
  end

`ifdef RPN_ALU_SAT_EN
  logic              ovf;
  logic [DATA_W-1:0] sat_val;
  assign ovf     = (wide[WW-1:DATA_W-1] != {(DATA_W+1){wide[DATA_W-1]}});
  assign sat_val = wide[WW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
  logic wide_unused;
  assign wide_unused = ^wide[WW-1:DATA_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 2'b00;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (op_start) op_q <= i_data[1:0];
      if (state == EXEC) begin
`ifdef RPN_ALU_SAT_EN
        res_q <= ovf ? sat_val : wide[DATA_W-1:0];
        ovf_q <= ovf;
`else
        res_q <= wide[DATA_W-1:0];
        ovf_q <= 1'b0;
`endif
      end
    end
  end

  // Stack storage needs no reset: every write is gated by state or an accepted token.
  always_ff @(posedge clk) begin
    if (push_en)           stack[push_idx] <= push_data;
    else if (state == WB)  stack[sec_idx]  <= res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth          <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_error        <= 1'b0;
      o_err_code     <= 2'b00;
    end else begin
      o_result_valid <= pop_en;
      if (clr_en) begin
        depth      <= '0;
        o_error    <= 1'b0;
        o_err_code <= 2'b00;
      end else begin
        if (push_en)                       depth <= depth + PW'(1);
        else if (pop_en || state == WB)    depth <= depth - PW'(1);
        if (pop_en) o_result <= stack[top_idx];
        if (err_set && !o_error) begin
          o_error    <= 1'b1;
          o_err_code <= err_code_n;
        end
      end
    end
  end

endmodule

// File: doc/rpn_alu_param.md
RPN_ALU_PARAM -- requirements
Module: rpn_alu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed operand/result width, at least 8.
REQ-002 SHALL have parameter DEPTH, default 16: internal stack entries, a power of 2, at least 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_data, input, 4 bits: token. 0x0-0x9 digit, 0xA '+', 0xB '-', 0xC '*', 0xD '=', 0xE DUP, 0xF CLEAR.
REQ-006 SHALL have port i_valid, input, 1 bit: i_data holds a token.
REQ-007 SHALL have port o_ready, output, 1 bit: the block accepts a token this cycle.
REQ-008 SHALL have port o_result, output, DATA_W bits: signed value popped by the last '='.
REQ-009 SHALL have port o_result_valid, output, 1 bit: one-cycle pulse when o_result updates.
REQ-010 SHALL have port o_error, output, 1 bit: sticky error flag.
REQ-011 SHALL have port o_err_code, output, 2 bits: 01 underflow, 10 stack overflow, 11 arithmetic overflow.
REQ-012 SHALL have port o_depth, output, $clog2(DEPTH)+1 bits: current stack occupancy.

Function
REQ-013 SHALL accept a token only in a cycle where i_valid and o_ready are both high; i_data is ignored in all other cycles.
REQ-014 SHALL implement FSM states IDLE, EXEC and WB; o_ready SHALL be high only in IDLE.
REQ-015 SHALL, on an accepted digit, push the digit zero-extended to DATA_W at that edge and remain in IDLE (one token per cycle throughput).
REQ-016 SHALL, on an accepted operator with depth >= 2, go to EXEC.
- EXEC: b = entry[depth-2], a = entry[depth-1]; register b+a, b-a or b*a, computed at 2*DATA_W internal width.
- WB: write the result to entry[depth-2], decrement depth, return to IDLE.
- Operator latency: result committed 2 cycles after acceptance.
REQ-017 SHALL, on '=' with depth >= 1, pop the top entry into o_result and pulse o_result_valid in the following cycle, remaining in IDLE.
REQ-018 SHALL, on DUP with 1 <= depth < DEPTH, push a copy of the top entry in one cycle.
REQ-019 SHALL, on CLEAR, set depth to 0, clear o_error and o_err_code, and accept tokens again from the next cycle.
REQ-020 SHALL, on an operator with depth < 2 or on '='/DUP with depth 0, leave the stack unchanged and set o_error with code 01.
REQ-021 SHALL, on a digit or DUP with depth == DEPTH, leave the stack unchanged and set o_error with code 10.
REQ-022 SHALL, while o_error is set, accept and discard every token except CLEAR; the first error code SHALL be held.
REQ-023 SHALL, when a CLEAR and an error condition coincide, give CLEAR priority.
REQ-024 SHALL NOT pulse o_result_valid on an erroneous '='.

Reset
REQ-025 SHALL, while rst_n is low, immediately force the following:
- state IDLE, depth 0, o_result 0;
- o_result_valid 0, o_error 0, o_err_code 00;
- o_ready 0; o_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-026 SHALL, on reset asserted mid-operation (EXEC/WB), abandon the operation without writing the stack.

Configuration
REQ-027 SHALL support macro RPN_ALU_SAT_EN.
- Defined: EXEC results outside the signed DATA_W range clamp to the max/min value, set o_error with code 11, and are still written.
- Undefined: results wrap modulo 2^DATA_W and code 11 never occurs.

Verification
REQ-028 SHALL cover tokens 3,4,A,D -> o_result=7 with one o_result_valid pulse; o_depth=0 afterwards.
REQ-029 SHALL cover tokens 2,5,B,D -> o_result=-3 (0xFFFFFFFD at DATA_W=32); operator o_ready low for exactly 2 cycles.
REQ-030 SHALL cover tokens 9,E,C,E,C,E,C,... with DATA_W=8.
- RPN_ALU_SAT_EN defined: the first product above 127 yields 127 and code 11.
- Undefined: 81*81 wraps to 0xA1.
REQ-031 SHALL cover 17 digits at DEPTH=16 -> code 10 after the 17th; then tokens are discarded until CLEAR; after CLEAR, 1,D -> o_result=1.
REQ-032 SHALL cover tokens A on an empty stack -> code 01, and o_depth stays 0.
REQ-033 SHALL cover rst_n pulsed low during EXEC of 6,7,C -> all outputs at reset values, o_depth=0, and no write of 42.
